// File: rtl/pulse_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_seq_pkg
//  Description : Shared constants for the pulse sequencer: register map,
//                mode encodings, control bit positions and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_seq_pkg;

  // Register map
  localparam int ADDR_PERIOD  = 0;
  localparam int ADDR_CTRL    = 1;
  localparam int ADDR_CH_BASE = 2;

  // Control register bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_ARM_BIT  = 3;

  // Run modes; the reserved code behaves as continuous
  localparam logic [1:0] MODE_CONT    = 2'd0;
  localparam logic [1:0] MODE_ONESHOT = 2'd1;
  localparam logic [1:0] MODE_TRIG    = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  // Sequencer state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : pulse_seq_pkg
`default_nettype wire

// File: rtl/pulse_sequencer_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_channel
//  Description : One sequencer output. Holds shadow and active start/width,
//                compares the frame count against [start, start+width) and
//                registers the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_channel
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_we,
  input  logic             width_we,
  input  logic [CNT_W-1:0] wdata,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] count,
  output logic             pulse
);

  logic [CNT_W-1:0] start_sh_q, start_sh_d;
  logic [CNT_W-1:0] width_sh_q, width_sh_d;
  logic [CNT_W-1:0] start_act_q, start_act_d;
  logic [CNT_W-1:0] width_act_q, width_act_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W:0]   stop;
  logic             in_window;

  // Shadow capture, active load and window compare (sum kept one bit wider)
  always_comb begin
    start_sh_d  = start_we ? wdata : start_sh_q;
    width_sh_d  = width_we ? wdata : width_sh_q;
    start_act_d = load ? start_sh_q : start_act_q;
    width_act_d = load ? width_sh_q : width_act_q;
    stop        = {1'b0, start_act_q} + {1'b0, width_act_q};
    in_window   = ({1'b0, count} >= {1'b0, start_act_q}) && ({1'b0, count} < stop);
    pulse_d     = run && in_window;
  end

  // Channel registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_sh_q  <= '0;
      width_sh_q  <= '0;
      start_act_q <= '0;
      width_act_q <= '0;
      pulse_q     <= 1'b0;
    end else begin
      start_sh_q  <= start_sh_d;
      width_sh_q  <= width_sh_d;
      start_act_q <= start_act_d;
      width_act_q <= width_act_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule : pulse_channel
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_sequencer
//  Description : Multi-channel pulse sequencer. A frame counter runs over a
//                programmable period; each channel fires one pulse per frame
//                at its own offset. Continuous, one-shot and trigger modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int N_CH           = 5,
  parameter int CNT_W          = 21,
  parameter int DEFAULT_PERIOD = 800000,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic              trig,
  output logic [N_CH-1:0]   ch_out,
  output logic              frame_strobe,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             strobe_q, strobe_d;
  logic             trig_s1_q, trig_s2_q, trig_s3_q;

  logic             ctrl_we;
  logic             period_we;
  logic             arm_now;
  logic [1:0]       mode_eff;
  logic             trig_rise;
  logic             frame_end;
  logic             load;
  logic             ch_run;

  // Trigger edge: two sync stages then compare against one more delayed copy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      trig_s1_q <= trig;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  assign trig_rise = trig_s2_q & ~trig_s3_q;

  // Config decode and shadow/active period; control decisions use the value being written
  always_comb begin
    ctrl_we      = cfg_we && (cfg_addr == ADDR_W'(ADDR_CTRL));
    period_we    = cfg_we && (cfg_addr == ADDR_W'(ADDR_PERIOD));
    en_d         = ctrl_we ? cfg_wdata[CTRL_EN_BIT] : en_q;
    mode_d       = ctrl_we ? cfg_wdata[CTRL_MODE_MSB:CTRL_MODE_LSB] : mode_q;
    arm_now      = ctrl_we && cfg_wdata[CTRL_ARM_BIT];
    mode_eff     = (mode_d == MODE_RSVD) ? MODE_CONT : mode_d;
    period_sh_d  = period_sh_q;
    if (period_we) begin
      period_sh_d = (cfg_wdata < CNT_W'(2)) ? CNT_W'(2) : cfg_wdata;
    end
    frame_end    = (state_q == ST_RUN) && (count_q == (period_act_q - CNT_W'(1)));
    load         = (state_q == ST_IDLE) || frame_end;
    period_act_d = load ? period_sh_q : period_act_q;
    ch_run       = (state_q == ST_RUN) && en_d;
  end

  // Next state and frame counter
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (en_d) begin
          case (mode_eff)
            MODE_CONT:    state_d = ST_RUN;
            MODE_ONESHOT: if (arm_now)   state_d = ST_RUN;
            MODE_TRIG:    if (trig_rise) state_d = ST_RUN;
            default:      state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (!en_d) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (frame_end) begin
          count_d = '0;
          if (mode_eff != MODE_CONT) begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
    strobe_d = (state_d == ST_RUN) && (count_d == '0);
  end

  // Sequencer state, counter, control and period registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      strobe_q     <= 1'b0;
      en_q         <= 1'b0;
      mode_q       <= MODE_CONT;
      period_sh_q  <= CNT_W'(DEFAULT_PERIOD);
      period_act_q <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      strobe_q     <= strobe_d;
      en_q         <= en_d;
      mode_q       <= mode_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam int c_start_addr = ADDR_CH_BASE + 2 * i;
      logic start_we;
      logic width_we;

      assign start_we = cfg_we && (cfg_addr == ADDR_W'(c_start_addr));
      assign width_we = cfg_we && (cfg_addr == ADDR_W'(c_start_addr + 1));

      pulse_channel #(
        .CNT_W (CNT_W)
      ) u_channel (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_we (start_we),
        .width_we (width_we),
        .wdata    (cfg_wdata),
        .load     (load),
        .run      (ch_run),
        .count    (count_q),
        .pulse    (ch_out[i])
      );
    end
  endgenerate

  assign frame_strobe = strobe_q;
  assign busy         = (state_q == ST_RUN);
  assign count        = count_q;

endmodule : pulse_sequencer
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_sequencer
//  Description : Directed self-checking bench for pulse_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer;

  localparam int N_CH           = 5;
  localparam int CNT_W          = 21;
  localparam int DEFAULT_PERIOD = 800000;
  localparam int ADDR_W         = 6;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic              trig;
  logic [N_CH-1:0]   ch_out;
  logic              frame_strobe;
  logic              busy;
  logic [CNT_W-1:0]  count;

  int total = 0;
  int bad   = 0;
  int hi    [N_CH];
  int first [N_CH];
  int last  [N_CH];
  int n_strobe;
  int n_busy;

  pulse_sequencer #(
    .N_CH           (N_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .trig         (trig),
    .ch_out       (ch_out),
    .frame_strobe (frame_strobe),
    .busy         (busy),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Register write; returns at the negedge after the write edge
  task automatic wr(input int a, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = ADDR_W'(a);
    cfg_wdata = CNT_W'(d);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < N_CH; i++) begin
      hi[i] = 0; first[i] = -1; last[i] = -1;
    end
    n_strobe = 0;
    n_busy   = 0;
  endtask

  // Advance n cycles, recording which count each high ch_out sample belongs to.
  // Optionally writes (waddr,wval) or pulses trig in the cycle where count==wr_at / trig_at.
  task automatic run_ticks(input int n, input int wr_at, input int waddr, input int wval,
                           input int trig_at);
    bit wdone = 0, tdone = 0, tpend = 0;
    int prev;
    for (int t = 0; t < n; t++) begin
      prev = int'(count);
      @(negedge clk);
      cfg_we = 1'b0;
      if (tpend) begin trig = 1'b0; tpend = 0; end
      for (int i = 0; i < N_CH; i++) begin
        if (ch_out[i]) begin
          hi[i]++;
          if (first[i] < 0) first[i] = prev;
          last[i] = prev;
        end
      end
      if (frame_strobe) n_strobe++;
      if (busy) n_busy++;
      if (!wdone && wr_at >= 0 && int'(count) == wr_at) begin
        cfg_we = 1'b1; cfg_addr = ADDR_W'(waddr); cfg_wdata = CNT_W'(wval); wdone = 1;
      end
      if (!tdone && trig_at >= 0 && int'(count) == trig_at) begin
        trig = 1'b1; tpend = 1; tdone = 1;
      end
    end
  endtask

  task automatic wait_cnt(input int target, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (int'(count) == target) ok = 1;
      else @(negedge clk);
    end
    if (int'(count) == target) ok = 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; trig = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({ch_out, frame_strobe, busy} !== 7'd0 || count !== '0) begin bad++;
      $display("FAIL reset_outputs got ch=%b fs=%b busy=%b cnt=%0d want 0", ch_out, frame_strobe, busy, count); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || count !== '0) begin bad++;
      $display("FAIL reset_idle got busy=%b cnt=%0d want 0/0", busy, count); end
  endtask

  task automatic test_continuous();
    wr(0, 1000); wr(2, 0); wr(3, 120); wr(4, 500); wr(5, 10); wr(1, 1);
    total++; if (busy !== 1'b1 || count !== '0 || frame_strobe !== 1'b1) begin bad++;
      $display("FAIL cont_entry got busy=%b cnt=%0d fs=%b want 1/0/1", busy, count, frame_strobe); end
    clr(); run_ticks(3000, -1, 0, 0, -1);
    total++; if (hi[0] !== 360 || first[0] !== 0 || last[0] !== 119) begin bad++;
      $display("FAIL cont_ch0 got hi=%0d first=%0d last=%0d want 360/0/119", hi[0], first[0], last[0]); end
    total++; if (hi[1] !== 30 || first[1] !== 500 || last[1] !== 509) begin bad++;
      $display("FAIL cont_ch1 got hi=%0d first=%0d last=%0d want 30/500/509", hi[1], first[1], last[1]); end
    total++; if (n_strobe !== 3) begin bad++;
      $display("FAIL cont_strobes got %0d want 3", n_strobe); end
  endtask

  task automatic test_shadow();
    clr(); run_ticks(1000, 300, 3, 50, -1);
    total++; if (hi[0] !== 120) begin bad++; $display("FAIL shadow_cur got %0d want 120", hi[0]); end
    clr(); run_ticks(1000, -1, 0, 0, -1);
    total++; if (hi[0] !== 50) begin bad++; $display("FAIL shadow_next got %0d want 50", hi[0]); end
    clr(); run_ticks(1000, 999, 3, 80, -1);
    total++; if (hi[0] !== 50) begin bad++; $display("FAIL shadow_wrapwr got %0d want 50", hi[0]); end
    clr(); run_ticks(1000, -1, 0, 0, -1);
    total++; if (hi[0] !== 50) begin bad++; $display("FAIL shadow_late1 got %0d want 50", hi[0]); end
    clr(); run_ticks(1000, -1, 0, 0, -1);
    total++; if (hi[0] !== 80) begin bad++; $display("FAIL shadow_late2 got %0d want 80", hi[0]); end
  endtask

  task automatic test_boundaries();
    wr(1, 0);
    wr(0, 100);
    wr(2, 5);   wr(3, 0);          // ch0: width 0
    wr(4, 50);  wr(5, 2097151);    // ch1: sum would overflow CNT_W
    wr(6, 90);  wr(7, 30);         // ch2: truncated at frame end
    wr(8, 100); wr(9, 5);          // ch3: start == period
    wr(10, 99); wr(11, 1);         // ch4: last count only
    wr(1, 1);
    clr(); run_ticks(300, -1, 0, 0, -1);
    total++; if (hi[0] !== 0) begin bad++; $display("FAIL bnd_width0 got %0d want 0", hi[0]); end
    total++; if (hi[1] !== 150 || first[1] !== 50 || last[1] !== 99) begin bad++;
      $display("FAIL bnd_nowrap got hi=%0d first=%0d last=%0d want 150/50/99", hi[1], first[1], last[1]); end
    total++; if (hi[2] !== 30 || first[2] !== 90 || last[2] !== 99) begin bad++;
      $display("FAIL bnd_trunc got hi=%0d first=%0d last=%0d want 30/90/99", hi[2], first[2], last[2]); end
    total++; if (hi[3] !== 0) begin bad++; $display("FAIL bnd_start_eq_period got %0d want 0", hi[3]); end
    total++; if (hi[4] !== 3 || first[4] !== 99) begin bad++;
      $display("FAIL bnd_lastcnt got hi=%0d first=%0d want 3/99", hi[4], first[4]); end
    wr(1, 0); wr(0, 1); wr(1, 1);
    clr(); run_ticks(10, -1, 0, 0, -1);
    total++; if (n_strobe !== 5 || count !== '0) begin bad++;
      $display("FAIL bnd_period_clamp got strobes=%0d cnt=%0d want 5/0", n_strobe, count); end
  endtask

  task automatic test_oneshot();
    wr(1, 0); wr(0, 200);
    wr(1, 'hB);   // enable, mode one-shot, arm
    total++; if (busy !== 1'b1 || count !== '0) begin bad++;
      $display("FAIL os_entry got busy=%b cnt=%0d want 1/0", busy, count); end
    clr(); run_ticks(400, -1, 0, 0, -1);
    // 199 further busy cycles after the entry cycle: 200 in total
    total++; if (n_busy !== 199 || n_strobe !== 0 || busy !== 1'b0) begin bad++;
      $display("FAIL os_frame got busy_cycles=%0d strobes=%0d busy=%b want 199/0/0", n_busy, n_strobe, busy); end
    wr(1, 'hB);
    clr(); run_ticks(400, -1, 0, 0, -1);
    total++; if (n_busy !== 199 || busy !== 1'b0) begin bad++;
      $display("FAIL os_rearm got busy_cycles=%0d busy=%b want 199/0", n_busy, busy); end
  endtask

  task automatic test_trigger();
    bit b1, b2;
    wr(1, 0); wr(0, 300); wr(1, 5);   // enable, mode trigger
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL trg_wait got busy=%b want 0", busy); end
    trig = 1'b1;
    @(negedge clk); trig = 1'b0; b1 = busy;
    @(negedge clk); b2 = busy;
    @(negedge clk);
    total++; if (b1 !== 1'b0 || b2 !== 1'b0 || busy !== 1'b1 || count !== '0) begin bad++;
      $display("FAIL trg_latency got busy@1=%b @2=%b @3=%b cnt=%0d want 0/0/1/0", b1, b2, busy, count); end
    clr(); run_ticks(600, -1, 0, 0, 150);
    total++; if (n_busy !== 299 || n_strobe !== 0) begin bad++;
      $display("FAIL trg_ignore got busy_cycles=%0d strobes=%0d want 299/0", n_busy, n_strobe); end
    trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL trg_again got busy=%b want 1", busy); end
    run_ticks(310, -1, 0, 0, -1);
    trig = 1'b1;
    clr(); run_ticks(1000, -1, 0, 0, -1);
    trig = 1'b0;
    total++; if (n_busy !== 300 || n_strobe !== 1) begin bad++;
      $display("FAIL trg_held got busy_cycles=%0d strobes=%0d want 300/1", n_busy, n_strobe); end
  endtask

  task automatic test_abort();
    bit ok;
    wr(1, 0); wr(0, 1000); wr(1, 1);
    wait_cnt(400, 2000, ok);
    total++; if (!ok || ch_out[1] !== 1'b1) begin bad++;
      $display("FAIL abort_pre got reached=%0d ch1=%b want 1/1", ok, ch_out[1]); end
    cfg_we = 1'b1; cfg_addr = ADDR_W'(1); cfg_wdata = '0;
    @(negedge clk); cfg_we = 1'b0;
    total++; if (ch_out !== '0 || count !== '0 || busy !== 1'b0 || frame_strobe !== 1'b0) begin bad++;
      $display("FAIL abort_post got ch=%b cnt=%0d busy=%b fs=%b want 0", ch_out, count, busy, frame_strobe); end
  endtask

  task automatic test_async_reset();
    bit ok;
    wr(1, 1);
    wait_cnt(60, 2000, ok);
    total++; if (!ok || ch_out[1] !== 1'b1) begin bad++;
      $display("FAIL areset_pre got reached=%0d ch1=%b want 1/1", ok, ch_out[1]); end
    #1 reset_n = 1'b0;
    #1;
    total++; if (ch_out !== '0 || count !== '0 || busy !== 1'b0 || frame_strobe !== 1'b0) begin bad++;
      $display("FAIL areset_now got ch=%b cnt=%0d busy=%b fs=%b want 0", ch_out, count, busy, frame_strobe); end
    @(negedge clk); reset_n = 1'b1;
    wr(1, 1);
    total++; if (busy !== 1'b1 || count !== '0) begin bad++;
      $display("FAIL areset_restart got busy=%b cnt=%0d want 1/0", busy, count); end
    clr(); run_ticks(1000, -1, 0, 0, -1);
    total++; if ((hi[0] + hi[1] + hi[2] + hi[3] + hi[4]) !== 0 || int'(count) !== 1000) begin bad++;
      $display("FAIL areset_defaults got highs=%0d cnt=%0d want 0/1000",
               hi[0] + hi[1] + hi[2] + hi[3] + hi[4], count); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_shadow();
    test_boundaries();
    test_oneshot();
    test_trigger();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pulse_sequencer
`default_nettype wire

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Programmable multi-channel pulse sequencer that replaces hard-coded laser and camera timing with runtime-configurable per-channel delay and width. A frame counter runs over a programmable period, and each channel drives a single pulse per frame at its own offset. Configuration arrives through a simple register write port from the UART command decoder. Supported modes are continuous, one-shot and external-trigger.

Parameters:
N_CH, 5, number of output channels (1..16)
CNT_W, 21, frame counter / timing register width in bits
DEFAULT_PERIOD, 800000, period register reset value in clk ticks (15 Hz at 12 MHz)
ADDR_W, 6, config address width; must satisfy 2+2*N_CH <= 2**ADDR_W

Ports:
clk  in  1  system clock, 12 MHz
reset_n  in  1  asynchronous active-low reset
cfg_we  in  1  register write strobe, one cycle
cfg_addr  in  ADDR_W  register address
cfg_wdata  in  CNT_W  write data
trig  in  1  external trigger, asynchronous to clk
ch_out  out  N_CH  channel pulse outputs, registered
frame_strobe  out  1  one-cycle pulse when count==0 in RUN
busy  out  1  high while state is RUN
count  out  CNT_W  current frame count, for debug

Behaviour:
- Reset: ch_out=0, frame_strobe=0, busy=0, count=0, state=IDLE.
- Reset values: period=DEFAULT_PERIOD, control=0, all start and width registers=0, for both shadow and active copies.
- Address map:
  - 0: period.
  - 1: control. bit0 enable, bits2:1 mode (0 continuous, 1 one-shot, 2 trigger, 3 reserved, treated as 0). bit3 arm is write-only and self-clearing.
  - 2+2i: start of channel i.
  - 3+2i: width of channel i.
  - Writes to unmapped addresses are ignored.
- Period writes below 2 are clamped to 2.
- Control takes effect on the cycle after the write.
- Period, start and width writes go to shadow registers. Shadow copies move to active copies every cycle in IDLE, and in RUN only on the cycle count wraps to 0.
- A write coinciding with the load cycle is not included in that load; it applies at the next boundary.
- Counter: in RUN, count increments 0..period-1 and then wraps to 0. In IDLE, count is held at 0.
- Channel i in RUN: ch_out[i] is the registered value of (count >= start_i) && (count < start_i + width_i).
  - The sum is computed in CNT_W+1 bits, so there is no wrap.
  - Output latency is 1 cycle from count.
  - width=0 means the channel never fires.
  - A pulse extending past period-1 is truncated at the frame end and does not carry into the next frame.
  - start >= period means the channel never fires.
- State machine (IDLE, RUN):
  - IDLE to RUN, continuous mode: enable=1.
  - IDLE to RUN, one-shot mode: a control write with enable=1 and arm=1.
  - IDLE to RUN, trigger mode: enable=1 and a rising edge of synchronised trig.
  - RUN to IDLE, one-shot and trigger modes: at the end of the cycle where count==period-1.
  - RUN to IDLE, any mode: on the cycle after enable is written 0. count goes to 0 and all ch_out go to 0 on the next cycle.
- Entering RUN starts at count=0 and asserts frame_strobe on that cycle. Entering RUN does not re-load active registers; they were already loaded in IDLE.
- trig path: 2-flop synchroniser plus edge detect, giving 3 cycles from the pin to the RUN entry decision.
  - Edges during RUN are ignored, not queued.
  - trig held high does not retrigger.
- Changing mode while in RUN takes effect at the next frame boundary.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Decomposition:
- Package pulse_seq_pkg holds:
  - address constants ADDR_PERIOD=0, ADDR_CTRL=1, ADDR_CH_BASE=2;
  - mode encodings MODE_CONT, MODE_ONESHOT, MODE_TRIG;
  - control bit indices;
  - state encoding.
- Sub-module pulse_channel: shadow and active start/width registers, load enable, window comparator, registered output. Instantiated N_CH times.
- The top level holds the config decode, the FSM, the counter and the trig synchroniser.

Test Plan:
- Continuous mode: period=1000, ch0 start=0 width=120, ch1 start=500 width=10, enable=1. Required: ch0 high for count 0..119 (ch_out one cycle later) and ch1 high for 500..509. frame_strobe fires every 1000 cycles for 3 frames.
- Shadow timing: mid-frame at count=300, write ch0 width=50. Required: the current frame still gives a 120-cycle pulse, and every later frame gives 50 cycles. A write landing exactly on the wrap cycle applies one frame later.
- Boundaries: period=100, ch2 start=90 width=30. Required: ch2 high for 10 cycles per frame and low at count 0..1. width=0 never fires. start=100 never fires. A period write of 1 reads back as behaving like period 2.
- One-shot: mode=1, control write enable=1 arm=1, period=200. Required: exactly one frame, busy high for 200 cycles, then IDLE. Re-arming runs one more frame.
- Trigger mode: period=300. Required: a trig pulse gives RUN entry 3 cycles later. A second trig at count 150 is ignored. A trig after return to IDLE starts a new frame. A trig held high for 1000 cycles gives a single frame.
- Abort and reset: while running, write enable=0 at count 400. Required: all outputs low and count=0 next cycle. Assert reset_n low mid-pulse: outputs 0 and registers back to defaults immediately.
